// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one iterative radix-2 Booth signed multiplier.
// Define BOOTH_ZERO_BYPASS_EN to skip the Booth steps when an operand is zero.
module booth_mul_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_prod,
  output logic              busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic [N:0]      acc_q, acc_d;
  logic            q1_q, q1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  prod_q, prod_d;
`ifdef BOOTH_ZERO_BYPASS_EN
  logic            zero_q, zero_d;
`endif

  logic            found;
  logic [IDW-1:0]  win;
  logic [N-1:0]    win_a, win_b;
  logic [N:0]      sum;
  logic [2*N+1:0]  shifted;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign win_a = req_a[int'(win)*N +: N];
  assign win_b = req_b[int'(win)*N +: N];

  // acc is N+1 bits so subtracting the most-negative A cannot overflow
  always_comb begin
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + {a_q[N-1], a_q};
      2'b10:   sum = acc_q - {a_q[N-1], a_q};
      default: sum = acc_q;
    endcase
  end

  assign shifted = {sum[N], sum, q_q};

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    q_d       = q_q;
    acc_d     = acc_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    req_ready = '0;
`ifdef BOOTH_ZERO_BYPASS_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = NREQ'(1) << win;
          a_d       = win_a;
          q_d       = win_b;
          acc_d     = '0;
          q1_d      = 1'b0;
          cnt_d     = '0;
          id_d      = win;
          rr_ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          state_d   = RUN;
`ifdef BOOTH_ZERO_BYPASS_EN
          zero_d    = (win_a == '0) || (win_b == '0);
`endif
        end
      end
      RUN: begin
`ifdef BOOTH_ZERO_BYPASS_EN
        if (zero_q) begin
          prod_d  = '0;
          state_d = DONE;
        end else begin
`else
        begin
`endif
          acc_d = shifted[2*N+1:N+1];
          q_d   = shifted[N:1];
          q1_d  = shifted[0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            prod_d  = shifted[2*N:1];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      q_q      <= '0;
      acc_q    <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
`ifdef BOOTH_ZERO_BYPASS_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      q1_q     <= q1_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`ifdef BOOTH_ZERO_BYPASS_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_prod  = prod_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: arbitration order, products,
// latency, backpressure and mid-operation reset.
module tb_booth_mul_arbiter;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 40;
`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 16;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_prod;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*N-1:0] prod;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  bit   ok;

  booth_mul_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] smul(logic [15:0] a, logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return sa * sb_;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [15:0] a, logic [15:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = 1'b1;
  endtask

  // returns cycles from the grant edge to rsp_valid, and whether busy
  // stayed high with no grants while waiting
  task automatic wait_valid(output int l, output bit good);
    l    = 0;
    good = 1'b1;
    forever begin
      #1;
      if (rsp_valid || l >= TMO) break;
      if (!busy || req_ready != '0) good = 1'b0;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic pop_exp(output exp_t x);
    if (sb.size() > 0) x = sb.pop_front();
    else x = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_prod !== '0) begin errors++; $display("FAIL rst_prod: got %h expected 0", rsp_prod); end
    checks++;
    if (rsp_id !== '0) begin errors++; $display("FAIL rst_id: got %0d expected 0", rsp_id); end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_round_robin();
    int id;
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'((i + 1) * 1371), 16'(-(i + 2) * 977));
    for (int g = 0; g < 5; g++) begin
      id = g % NREQ;
      #1;
      checks++;
      if (req_ready !== NREQ'(1 << id)) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, NREQ'(1 << id));
      end
      sb.push_back({IDW'(id), smul(req_a[id*N +: N], req_b[id*N +: N])});
      step();
      if (g == 0) req_a[0 +: N] = 16'h7ABC;
      wait_valid(lat, ok);
      checks++;
      if (lat != 16) begin errors++; $display("FAIL rr_lat%0d: got %0d expected 16", g, lat); end
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_busy%0d: got grant/idle while busy expected none", g); end
      pop_exp(e);
      checks++;
      if (rsp_id !== e.id) begin errors++; $display("FAIL rr_id%0d: got %0d expected %0d", g, rsp_id, e.id); end
      checks++;
      if (rsp_prod !== e.prod) begin errors++; $display("FAIL rr_prod%0d: got %h expected %h", g, rsp_prod, e.prod); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    step();
    rsp_ready = 1'b1;
    set_req(0, 16'd3, 16'hFFFB);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
    sb.push_back({IDW'(0), 32'hFFFF_FFF1});
    step();
    req_valid = '0;
    wait_valid(lat, ok);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL single_lat: got %0d expected 16", lat); end
    checks++;
    if (!ok) begin errors++; $display("FAIL single_busy: got busy low or grant expected busy"); end
    pop_exp(e);
    checks++;
    if (rsp_prod !== e.prod) begin errors++; $display("FAIL single_prod: got %h expected %h", rsp_prod, e.prod); end
    checks++;
    if (rsp_id !== e.id) begin errors++; $display("FAIL single_id: got %0d expected %0d", rsp_id, e.id); end
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    checks++;
    if (rsp_prod !== 32'hFFFF_FFF1) begin errors++; $display("FAIL single_hold: got %h expected fffffff1", rsp_prod); end
  endtask

  task automatic test_extreme();
    logic [15:0] ta[3] = '{16'h8000, 16'h8000, 16'h7FFF};
    logic [15:0] tb[3] = '{16'h8000, 16'h7FFF, 16'h7FFF};
    logic [31:0] tp[3] = '{32'h4000_0000, 32'hC000_8000, 32'h3FFF_0001};
    for (int k = 0; k < 3; k++) begin
      step();
      set_req(1, ta[k], tb[k]);
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL ext_grant%0d: got %b expected 0010", k, req_ready); end
      sb.push_back({IDW'(1), tp[k]});
      step();
      req_valid = '0;
      wait_valid(lat, ok);
      checks++;
      if (lat != 16) begin errors++; $display("FAIL ext_lat%0d: got %0d expected 16", k, lat); end
      pop_exp(e);
      checks++;
      if (rsp_prod !== e.prod || rsp_id !== e.id) begin
        errors++; $display("FAIL ext_prod%0d: got %h id %0d expected %h id %0d", k, rsp_prod, rsp_id, e.prod, e.id);
      end
      step();
    end
  endtask

  task automatic test_zero();
    step();
    rsp_ready = 1'b1;
    set_req(1, 16'h0000, 16'h1234);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_grant: got %b expected 0010", req_ready); end
    sb.push_back({IDW'(1), 32'h0});
    step();
    req_valid = '0;
    wait_valid(lat, ok);
    checks++;
    if (lat != ZLAT) begin errors++; $display("FAIL zero_lat: got %0d expected %0d", lat, ZLAT); end
    pop_exp(e);
    checks++;
    if (rsp_prod !== e.prod || rsp_id !== e.id) begin
      errors++; $display("FAIL zero_prod: got %h id %0d expected %h id %0d", rsp_prod, rsp_id, e.prod, e.id);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t held;
    step();
    rsp_ready = 1'b0;
    set_req(2, 16'h1234, 16'hFF00);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
    sb.push_back({IDW'(2), smul(16'h1234, 16'hFF00)});
    step();
    req_valid[2] = 1'b0;
    set_req(3, 16'hC001, 16'h00FF);
    wait_valid(lat, ok);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL bp_lat: got %0d expected 16", lat); end
    pop_exp(held);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_prod !== held.prod || rsp_id !== held.id || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b p=%h id=%0d rdy=%b expected v=1 p=%h id=%0d rdy=0000",
                 k, rsp_valid, rsp_prod, rsp_id, req_ready, held.prod, held.id);
      end
      step();
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_bubble: got %b expected 0000", req_ready); end
    step();
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next: got %b expected 1000", req_ready); end
    sb.push_back({IDW'(3), smul(16'hC001, 16'h00FF)});
    step();
    req_valid = '0;
    wait_valid(lat, ok);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL bp_lat2: got %0d expected 16", lat); end
    pop_exp(e);
    checks++;
    if (rsp_prod !== e.prod || rsp_id !== e.id) begin
      errors++; $display("FAIL bp_prod2: got %h id %0d expected %h id %0d", rsp_prod, rsp_id, e.prod, e.id);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    step();
    rsp_ready = 1'b1;
    set_req(1, 16'h0ABC, 16'h0DEF);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mr_grant: got %b expected 0010", req_ready); end
    step();
    req_valid = '0;
    set_req(2, 16'hF00D, 16'h0123);
    repeat (7) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mr_state: got busy=%b valid=%b expected 0 0", busy, rsp_valid);
    end
    checks++;
    if (rsp_prod !== '0 || rsp_id !== '0) begin
      errors++; $display("FAIL mr_clear: got prod=%h id=%0d expected 0 0", rsp_prod, rsp_id);
    end
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL mr_pending: got %b expected 0100", req_ready); end
    sb.push_back({IDW'(2), smul(16'hF00D, 16'h0123)});
    step();
    req_valid = '0;
    wait_valid(lat, ok);
    checks++;
    if (lat != 16) begin errors++; $display("FAIL mr_lat: got %0d expected 16", lat); end
    pop_exp(e);
    checks++;
    if (rsp_prod !== e.prod || rsp_id !== e.id) begin
      errors++; $display("FAIL mr_prod: got %h id %0d expected %h id %0d", rsp_prod, rsp_id, e.prod, e.id);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_extreme();
    test_zero();
    test_backpressure();
    test_reset_midrun();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Shares one iterative radix-2 Booth signed multiplier between NREQ requesters.
- Arbitrates round-robin, latches the winner's operands and sequences N add/sub + arithmetic-shift steps.
- Returns the 2N-bit product tagged with the requester index over a valid/ready response channel.
- Sits between multiply-issuing clients and the shared multiply resource; only one multiply is in flight at a time.

Parameters:
- N, 16, operand width (signed two's complement).
- NREQ, 4, number of requesters (≥2).
- IDW, 2, requester-id width (≥ clog2(NREQ)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
- req_a  in  NREQ*N  multiplicands; requester i at [i*N +: N]
- req_b  in  NREQ*N  multipliers; requester i at [i*N +: N]
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_id  out  IDW  index of requester that issued the product
- rsp_prod  out  2N  signed product a*b
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, sampled on the clk edge with reset==0:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0, step count=0.
  - Reset mid-RUN or mid-DONE aborts the operation; no response is produced.
- FSM IDLE/RUN/DONE:
  - IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1 … wrapping modulo NREQ.
    - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
    - req_ready is all zero outside IDLE, or when no req_valid is set.
    - On handshake (req_valid[w] & req_ready[w]): latch A=req_a[w] and Q=req_b[w], set acc=0, q_1=0, cnt=0, rsp_id=w, rr_ptr=(w+1) mod NREQ; go to RUN.
  - RUN: one Booth step per edge.
    - {Q[0],q_1}=01: acc += sext(A). =10: acc -= sext(A). 00/11: no change.
    - Then arithmetic right shift of {acc,Q,q_1} by one.
    - acc is N+1 bits so that subtracting the most-negative A cannot overflow.
    - cnt increments; on the edge performing step N-1, go to DONE and load rsp_prod={acc,Q}[2N-1:0] of the post-shift value.
  - DONE: rsp_valid=1; rsp_prod and rsp_id held stable while rsp_ready=0.
    - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
    - No new request is accepted in the handshake cycle; there is a one-cycle bubble.
- Latency:
  - rsp_valid is visible exactly N cycles after the request handshake edge.
  - Throughput is at most one product per N+2 cycles.
- Request hygiene:
  - Requesters may drop req_valid before being granted; this has no effect.
  - Operand changes after the handshake are ignored.
  - Requests that arrive during RUN/DONE wait and are not lost.
- Product is the exact signed product for all operand pairs, including -2^(N-1) × -2^(N-1) = 2^(2N-2).
- rsp_prod and rsp_id retain their last values after the response handshake.

Optional Feature:
- Macro: BOOTH_ZERO_BYPASS_EN.
- Defined:
  - At handshake, if the granted req_a or req_b equals 0, skip RUN: go directly to DONE with rsp_prod=0.
  - rsp_valid is then visible 1 cycle after the handshake edge; arbitration and rsp_id are unchanged.
- Undefined: zero operands take the full N-step path; latency is always N.

Test Plan:
- Single request, requester 0, a=3, b=-5 (0xFFFB), rsp_ready=1:
  - req_ready[0] in the same cycle.
  - rsp_valid 16 cycles after handshake, rsp_prod=0xFFFFFFF1, rsp_id=0.
  - busy high from handshake until the response handshake.
- Extreme operands, a=b=0x8000 → rsp_prod=0x40000000. a=0x8000, b=0x7FFF → 0xC0008000. a=0x7FFF, b=0x7FFF → 0x3FFF0001.
- All four requesters valid continuously with distinct operands:
  - Grants and rsp_id in order 0,1,2,3,0.
  - No req_ready while busy.
  - Each product correct.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE.
  - rsp_valid, rsp_prod and rsp_id are stable.
  - req_ready stays 0.
  - On release, rsp_valid drops and the next grant occurs one cycle later.
- Reset asserted at RUN step 7:
  - Next cycle busy=0, rsp_valid=0, rsp_prod=0, rr_ptr=0.
  - A pending request on requester 2 is then granted, and its product is correct.
- Zero operand a=0, b=0x1234:
  - With BOOTH_ZERO_BYPASS_EN: rsp_valid 1 cycle after handshake, rsp_prod=0.
  - Without it: rsp_valid after 16 cycles, rsp_prod=0.
